// File: rtl/ccff_chain_loader.sv
// Purpose: serialises configuration words onto the config-FF chain head and captures tail bits as readback words.
// Latency: one handshake cycle plus one shift cycle per chain bit per word; readback word appears the cycle after its last bit.
// Backpressure: cfg_ready is high only in LOAD, so words stall there indefinitely; rb_valid has no backpressure.
module ccff_chain_loader #(
    parameter int WORD_WIDTH   = 8,
    parameter int CHAIN_LENGTH = 30,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  ccff_head,
    output logic                  ccff_shift_en,
    input  logic                  ccff_tail,
    output logic [WORD_WIDTH-1:0] rb_data,
    output logic                  rb_valid,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CHAIN_LEN_C = CNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [CNT_WIDTH-1:0] WORD_W_C    = CNT_WIDTH'(WORD_WIDTH);
    localparam logic [CNT_WIDTH-1:0] ONE_C       = CNT_WIDTH'(1);

    state_t                state;
    state_t                state_nxt;

    // Outgoing word, already advanced past the bit currently on ccff_head.
    logic [WORD_WIDTH-1:0] cfg_shreg;
    // Partially assembled readback word; unfilled positions stay zero.
    logic [WORD_WIDTH-1:0] rb_shreg;
    logic [WORD_WIDTH-1:0] rb_merged;

    logic [CNT_WIDTH-1:0]  bits_sent;   // chain bits shifted so far in this load
    logic [CNT_WIDTH-1:0]  word_bit;    // bit position within the current word
    logic [CNT_WIDTH-1:0]  word_bits;   // number of bits of the current word that go into the chain
    logic [CNT_WIDTH-1:0]  bits_left;
    logic [CNT_WIDTH-1:0]  load_bits;

    logic                  word_last;   // this shift cycle carries the last bit of the word
    logic                  chain_last;  // this shift cycle carries the last bit of the chain
    logic                  rb_word_end; // readback word completes on this shift cycle

    // State register; reset aborts any load in flight.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, state-derived outputs and per-cycle shift bookkeeping.
    always_comb begin
        state_nxt   = state;
        cfg_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        bits_left   = CHAIN_LEN_C - bits_sent;
        load_bits   = (bits_left < WORD_W_C) ? bits_left : WORD_W_C;
        word_last   = (word_bit == (word_bits - ONE_C));
        chain_last  = ((bits_sent + ONE_C) >= CHAIN_LEN_C);
        rb_word_end = (word_bit == (WORD_W_C - ONE_C)) || chain_last;
        rb_merged   = rb_shreg | (WORD_WIDTH'(ccff_tail) << word_bit);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (cfg_valid) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (word_last) begin
                    state_nxt = chain_last ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: word latch, serialiser, counters and readback assembly.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            cfg_shreg     <= '0;
            rb_shreg      <= '0;
            rb_data       <= '0;
            rb_valid      <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            bits_sent     <= '0;
            word_bit      <= '0;
            word_bits     <= '0;
        end else begin
            rb_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        bits_sent <= '0;
                        word_bit  <= '0;
                        rb_shreg  <= '0;
                    end
                end
                ST_LOAD: begin
                    // Bit 0 goes straight onto the head so the first shift cycle follows the handshake.
                    if (cfg_valid) begin
                        cfg_shreg     <= cfg_data >> 1;
                        ccff_head     <= cfg_data[0];
                        ccff_shift_en <= 1'b1;
                        word_bits     <= load_bits;
                    end
                end
                ST_SHIFT: begin
                    if (bits_sent < CHAIN_LEN_C) begin
                        bits_sent <= bits_sent + ONE_C;
                    end
                    // Tail bit sampled here is the value before this cycle's shift edge.
                    if (rb_word_end) begin
                        rb_data  <= rb_merged;
                        rb_valid <= 1'b1;
                        rb_shreg <= '0;
                        word_bit <= '0;
                    end else begin
                        rb_shreg <= rb_merged;
                        word_bit <= word_bit + ONE_C;
                    end
                    // Upper bits of a partial final word are simply never presented.
                    if (word_last) begin
                        ccff_head     <= 1'b0;
                        ccff_shift_en <= 1'b0;
                    end else begin
                        ccff_head <= cfg_shreg[0];
                        cfg_shreg <= cfg_shreg >> 1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

    logic prog_clk;
    logic prog_reset;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance A: 10-bit chain, 4-bit words ----------------
    logic       a_start, a_cfg_valid, a_cfg_ready, a_head, a_sen, a_tail, a_rb_valid, a_busy, a_done;
    logic [3:0] a_cfg_data, a_rb_data;

    ccff_chain_loader #(.WORD_WIDTH(4), .CHAIN_LENGTH(10), .CNT_WIDTH(8)) dut_a (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(a_start),
        .cfg_data(a_cfg_data), .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
        .ccff_head(a_head), .ccff_shift_en(a_sen), .ccff_tail(a_tail),
        .rb_data(a_rb_data), .rb_valid(a_rb_valid), .busy(a_busy), .done(a_done));

    // ---------------- instance B: 8-bit chain, 8-bit words ----------------
    logic       b_start, b_cfg_valid, b_cfg_ready, b_head, b_sen, b_tail, b_rb_valid, b_busy, b_done;
    logic [7:0] b_cfg_data, b_rb_data;

    ccff_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(8), .CNT_WIDTH(4)) dut_b (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(b_start),
        .cfg_data(b_cfg_data), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
        .ccff_head(b_head), .ccff_shift_en(b_sen), .ccff_tail(b_tail),
        .rb_data(b_rb_data), .rb_valid(b_rb_valid), .busy(b_busy), .done(b_done));

    initial begin
        prog_clk = 1'b0;
        forever #5 prog_clk = ~prog_clk;
    end

    // Chain models: bit 0 is the tail DFF, head enters at the top on each enabled edge.
    logic [9:0] a_chain, a_pre_val;
    logic       a_pre_en;
    logic [7:0] b_chain, b_pre_val;
    logic       b_pre_en;

    always @(posedge prog_clk) begin
        if (a_pre_en) a_chain <= a_pre_val;
        else if (a_sen) a_chain <= {a_head, a_chain[9:1]};
        if (b_pre_en) b_chain <= b_pre_val;
        else if (b_sen) b_chain <= {b_head, b_chain[7:1]};
    end
    assign a_tail = a_chain[0];
    assign b_tail = b_chain[0];

    // Monitors sample mid-cycle, away from the active edge.
    logic       a_head_q[$];
    logic [3:0] a_rb_q[$];
    logic [7:0] b_rb_q[$];
    int a_hs_cnt = 0, a_sen_cnt = 0, a_done_after_shift = 0;
    int b_sen_cnt = 0;
    logic a_prev_sen = 1'b0;

    always @(negedge prog_clk) begin
        if (a_sen === 1'b1) begin a_head_q.push_back(a_head); a_sen_cnt++; end
        if (a_rb_valid === 1'b1) a_rb_q.push_back(a_rb_data);
        if (a_cfg_valid === 1'b1 && a_cfg_ready === 1'b1) a_hs_cnt++;
        if (a_done === 1'b1 && a_prev_sen === 1'b1) a_done_after_shift++;
        a_prev_sen = a_sen;
        if (b_sen === 1'b1) b_sen_cnt++;
        if (b_rb_valid === 1'b1) b_rb_q.push_back(b_rb_data);
    end

    int a_timeouts = 0, a_stall_bad = 0, a_stall_cnt = 0, b_timeouts = 0;
    logic [9:0] a_exp_chain;   // chain contents implied by the last completed load

    // Reference: readback word k is chain bits [4k+3:4k], zero-padded past the chain end.
    function automatic logic [3:0] rb_word(input logic [9:0] chain, input int k);
        logic [11:0] ext;
        ext = {2'b00, chain};
        return 4'(ext >> (4 * k));
    endfunction

    function automatic logic [9:0] a_stream(input int base);
        logic [9:0] v;
        v = '0;
        for (int i = 0; i < 10; i++)
            if (base + i < a_head_q.size()) v[i] = a_head_q[base + i];
        return v;
    endfunction

    task automatic a_preload(input logic [9:0] v);
        a_pre_val = v; a_pre_en = 1'b1;
        @(posedge prog_clk) #1;
        a_pre_en = 1'b0;
    endtask

    // One complete load on A: three words, optional stall before one word, optional start pulse mid-shift.
    task automatic a_run(input logic [11:0] words, input int stall_idx, input int stall_len, input bit mid_start);
        int g;
        bit hs;
        a_start = 1'b1;
        @(posedge prog_clk) #1;
        a_start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            a_cfg_valid = 1'b0;
            if (w == stall_idx && stall_len > 0) begin
                g = 0;
                @(negedge prog_clk);
                while (a_cfg_ready !== 1'b1 && g < 100) begin @(negedge prog_clk); g++; end
                if (g >= 100) a_timeouts++;
                for (int s = 0; s < stall_len; s++) begin
                    if (s > 0) @(negedge prog_clk);
                    a_stall_cnt++;
                    if (!(a_cfg_ready === 1'b1 && a_sen === 1'b0 && a_busy === 1'b1)) a_stall_bad++;
                end
                @(posedge prog_clk) #1;
            end
            a_cfg_valid = 1'b1;
            a_cfg_data  = words[w*4 +: 4];
            g = 0; hs = 1'b0;
            while (!hs && g < 100) begin
                @(negedge prog_clk);
                hs = (a_cfg_ready === 1'b1);
                @(posedge prog_clk) #1;
                g++;
            end
            if (!hs) a_timeouts++;
            a_cfg_valid = 1'b0;
            if (mid_start && w == 0) begin
                a_start = 1'b1;
                @(posedge prog_clk) #1;
                a_start = 1'b0;
            end
        end
        g = 0;
        @(negedge prog_clk);
        while (a_done !== 1'b1 && g < 100) begin @(negedge prog_clk); g++; end
        if (g >= 100) a_timeouts++;
        @(posedge prog_clk) #1;
    endtask

    task automatic b_run(input logic [7:0] word);
        int g;
        bit hs;
        b_start = 1'b1;
        @(posedge prog_clk) #1;
        b_start = 1'b0;
        b_cfg_valid = 1'b1;
        b_cfg_data  = word;
        g = 0; hs = 1'b0;
        while (!hs && g < 100) begin
            @(negedge prog_clk);
            hs = (b_cfg_ready === 1'b1);
            @(posedge prog_clk) #1;
            g++;
        end
        if (!hs) b_timeouts++;
        b_cfg_valid = 1'b0;
        g = 0;
        @(negedge prog_clk);
        while (b_done !== 1'b1 && g < 100) begin @(negedge prog_clk); g++; end
        if (g >= 100) b_timeouts++;
        @(posedge prog_clk) #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        n_cmp++;
        if ({a_cfg_ready, a_head, a_sen, a_rb_data, a_rb_valid, a_busy, a_done} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_a: outputs %b, want all zero", {a_cfg_ready, a_head, a_sen, a_rb_data, a_rb_valid, a_busy, a_done});
        end
        n_cmp++;
        if ({b_cfg_ready, b_head, b_sen, b_rb_data, b_rb_valid, b_busy, b_done} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_b: outputs %b, want all zero", {b_cfg_ready, b_head, b_sen, b_rb_data, b_rb_valid, b_busy, b_done});
        end
        @(posedge prog_clk) #1;
        prog_reset = 1'b0;
        // start with cfg_valid in IDLE: no acceptance that cycle
        a_start = 1'b1; a_cfg_valid = 1'b1; a_cfg_data = 4'h9;
        @(negedge prog_clk);
        n_cmp++;
        if (a_cfg_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ready: got %b want 0", a_cfg_ready); end
        @(posedge prog_clk) #1;
        a_start = 1'b0; a_cfg_valid = 1'b0;
        @(negedge prog_clk);
        n_cmp++;
        if (a_busy !== 1'b1 || a_cfg_ready !== 1'b1) begin
            n_bad++; $display("FAIL load_entry: busy %b ready %b want 1 1", a_busy, a_cfg_ready);
        end
        @(posedge prog_clk) #1;
        prog_reset = 1'b1;
        @(posedge prog_clk) #1;
        prog_reset = 1'b0;
    endtask

    task automatic test_basic;
        int hb, sb, cb, rb, db, tb0;
        a_preload(10'h2B5);
        a_exp_chain = 10'h2B5;
        hb = a_head_q.size(); sb = a_sen_cnt; cb = a_hs_cnt; rb = a_rb_q.size(); db = a_done_after_shift; tb0 = a_timeouts;
        a_run(12'h35A, -1, 0, 1'b0);
        n_cmp++;
        if (a_timeouts != tb0) begin n_bad++; $display("FAIL basic_timeout: %0d timeouts want 0", a_timeouts - tb0); end
        n_cmp++;
        if (a_stream(hb) !== 10'h35A) begin n_bad++; $display("FAIL basic_stream: got %h want %h", a_stream(hb), 10'h35A); end
        n_cmp++;
        if (a_sen_cnt - sb != 10) begin n_bad++; $display("FAIL basic_shifts: got %0d want 10", a_sen_cnt - sb); end
        n_cmp++;
        if (a_hs_cnt - cb != 3) begin n_bad++; $display("FAIL basic_words: got %0d want 3", a_hs_cnt - cb); end
        n_cmp++;
        if (a_done_after_shift - db != 1) begin n_bad++; $display("FAIL basic_done_timing: got %0d want 1", a_done_after_shift - db); end
        n_cmp++;
        if (a_rb_q.size() - rb != 3) begin n_bad++; $display("FAIL basic_rb_count: got %0d want 3", a_rb_q.size() - rb); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (a_rb_q.size() > rb + k && a_rb_q[rb + k] !== rb_word(a_exp_chain, k)) begin
                n_bad++; $display("FAIL basic_rb%0d: got %h want %h", k, a_rb_q[rb + k], rb_word(a_exp_chain, k));
            end
        end
        n_cmp++;
        if (a_done !== 1'b1 || a_busy !== 1'b0) begin n_bad++; $display("FAIL basic_flags: done %b busy %b want 1 0", a_done, a_busy); end
        n_cmp++;
        if (a_chain !== 10'h35A) begin n_bad++; $display("FAIL basic_chain: got %h want %h", a_chain, 10'h35A); end
        a_exp_chain = 10'h35A;
    endtask

    task automatic test_stall;
        int hb, sb, rb, stb, sbb;
        hb = a_head_q.size(); sb = a_sen_cnt; rb = a_rb_q.size(); stb = a_stall_cnt; sbb = a_stall_bad;
        a_run(12'h35A, 2, 5, 1'b0);
        n_cmp++;
        if (a_stall_cnt - stb != 5 || a_stall_bad != sbb) begin
            n_bad++; $display("FAIL stall_cycles: observed %0d bad %0d want 5 bad 0", a_stall_cnt - stb, a_stall_bad - sbb);
        end
        n_cmp++;
        if (a_stream(hb) !== 10'h35A || a_sen_cnt - sb != 10) begin
            n_bad++; $display("FAIL stall_stream: got %h/%0d want %h/10", a_stream(hb), a_sen_cnt - sb, 10'h35A);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (a_rb_q.size() <= rb + k || a_rb_q[rb + k] !== rb_word(a_exp_chain, k)) begin
                n_bad++; $display("FAIL stall_rb%0d: got %h want %h", k, (a_rb_q.size() > rb + k) ? a_rb_q[rb + k] : 4'hx, rb_word(a_exp_chain, k));
            end
        end
    endtask

    task automatic test_reset_abort;
        int n, g, hb, rb, sb, cb;
        logic [11:0] w;
        hb = a_head_q.size(); rb = a_rb_q.size();
        a_start = 1'b1;
        @(posedge prog_clk) #1;
        a_start = 1'b0;
        a_cfg_valid = 1'b1; a_cfg_data = 4'hF;
        n = 0; g = 0;
        while (n < 6 && g < 200) begin
            @(negedge prog_clk);
            if (a_sen === 1'b1) n++;
            g++;
        end
        n_cmp++;
        if (n != 6) begin n_bad++; $display("FAIL abort_reach: got %0d shifts want 6", n); end
        @(posedge prog_clk) #3;
        prog_reset = 1'b1;
        #1;
        n_cmp++;
        if ({a_cfg_ready, a_head, a_sen, a_rb_data, a_rb_valid, a_busy, a_done} !== 10'd0) begin
            n_bad++; $display("FAIL abort_outputs: %b want all zero", {a_cfg_ready, a_head, a_sen, a_rb_data, a_rb_valid, a_busy, a_done});
        end
        a_cfg_valid = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1 prog_reset = 1'b0;
        repeat (3) @(posedge prog_clk);
        #1;
        n_cmp++;
        if (a_rb_q.size() - rb != 6 / 4 || a_head_q.size() - hb != 6) begin
            n_bad++; $display("FAIL abort_rb: rb %0d bits %0d want 1 and 6", a_rb_q.size() - rb, a_head_q.size() - hb);
        end
        w = 12'($urandom);
        hb = a_head_q.size(); sb = a_sen_cnt; cb = a_hs_cnt;
        a_run(w, -1, 0, 1'b0);
        n_cmp++;
        if (a_stream(hb) !== w[9:0] || a_sen_cnt - sb != 10 || a_hs_cnt - cb != 3) begin
            n_bad++; $display("FAIL abort_reload: got %h/%0d/%0d want %h/10/3", a_stream(hb), a_sen_cnt - sb, a_hs_cnt - cb, w[9:0]);
        end
        n_cmp++;
        if (a_chain !== w[9:0]) begin n_bad++; $display("FAIL abort_chain: got %h want %h", a_chain, w[9:0]); end
        a_exp_chain = w[9:0];
    endtask

    task automatic test_mid_start;
        int hb, sb, cb;
        logic [11:0] w;
        w = 12'($urandom);
        hb = a_head_q.size(); sb = a_sen_cnt; cb = a_hs_cnt;
        a_run(w, -1, 0, 1'b1);
        n_cmp++;
        if (a_sen_cnt - sb != 10 || a_hs_cnt - cb != 3) begin
            n_bad++; $display("FAIL midstart_counts: shifts %0d words %0d want 10 3", a_sen_cnt - sb, a_hs_cnt - cb);
        end
        n_cmp++;
        if (a_stream(hb) !== w[9:0]) begin n_bad++; $display("FAIL midstart_stream: got %h want %h", a_stream(hb), w[9:0]); end
        a_exp_chain = w[9:0];
    endtask

    task automatic test_back_to_back;
        int hb, sb, rb, tb0;
        logic [11:0] w;
        for (int it = 0; it < 6; it++) begin
            w = 12'($urandom);
            hb = a_head_q.size(); sb = a_sen_cnt; rb = a_rb_q.size(); tb0 = a_timeouts;
            a_run(w, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            n_cmp++;
            if (a_stream(hb) !== w[9:0] || a_sen_cnt - sb != 10 || a_timeouts != tb0) begin
                n_bad++; $display("FAIL b2b_stream[%0d]: got %h/%0d want %h/10", it, a_stream(hb), a_sen_cnt - sb, w[9:0]);
            end
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (a_rb_q.size() <= rb + k || a_rb_q[rb + k] !== rb_word(a_exp_chain, k)) begin
                    n_bad++; $display("FAIL b2b_rb[%0d][%0d]: got %h want %h", it, k, (a_rb_q.size() > rb + k) ? a_rb_q[rb + k] : 4'hx, rb_word(a_exp_chain, k));
                end
            end
            a_exp_chain = w[9:0];
        end
    endtask

    task automatic test_wide_loopback;
        int rb, sb;
        logic [7:0] p;
        p = 8'($urandom);
        b_pre_val = p; b_pre_en = 1'b1;
        @(posedge prog_clk) #1;
        b_pre_en = 1'b0;
        rb = b_rb_q.size(); sb = b_sen_cnt;
        b_run(8'hC3);
        n_cmp++;
        if (b_rb_q.size() - rb != 1 || b_sen_cnt - sb != 8 || b_timeouts != 0) begin
            n_bad++; $display("FAIL wide_first_counts: rb %0d shifts %0d want 1 8", b_rb_q.size() - rb, b_sen_cnt - sb);
        end
        n_cmp++;
        if (b_rb_q.size() <= rb || b_rb_q[rb] !== p) begin
            n_bad++; $display("FAIL wide_first_rb: got %h want %h", (b_rb_q.size() > rb) ? b_rb_q[rb] : 8'hxx, p);
        end
        rb = b_rb_q.size(); sb = b_sen_cnt;
        b_run(8'hC3);
        n_cmp++;
        if (b_rb_q.size() - rb != 1 || b_sen_cnt - sb != 8 || b_timeouts != 0) begin
            n_bad++; $display("FAIL wide_loop_counts: rb %0d shifts %0d want 1 8", b_rb_q.size() - rb, b_sen_cnt - sb);
        end
        n_cmp++;
        if (b_rb_q.size() <= rb || b_rb_q[rb] !== 8'hC3) begin
            n_bad++; $display("FAIL wide_loop_rb: got %h want c3", (b_rb_q.size() > rb) ? b_rb_q[rb] : 8'hxx);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        prog_reset = 1'b1;
        a_start = 1'b0; a_cfg_valid = 1'b0; a_cfg_data = '0; a_pre_en = 1'b0; a_pre_val = '0;
        b_start = 1'b0; b_cfg_valid = 1'b0; b_cfg_data = '0; b_pre_en = 1'b0; b_pre_val = '0;
        a_exp_chain = '0;
        a_preload(10'h000);
        b_pre_val = 8'h00; b_pre_en = 1'b1;
        @(posedge prog_clk) #1;
        b_pre_en = 1'b0;
        test_reset;
        test_basic;
        test_stall;
        test_reset_abort;
        test_mid_start;
        test_back_to_back;
        test_wide_loopback;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
